// File: rtl/instruction_fetch_buffer.sv
// Single-line instruction fetch buffer: one 16-byte line with tag and valid bit,
// fixed-latency refill from instruction memory, and saturating hit/miss counters.
module instruction_fetch_buffer #(
  parameter int FILL_CYCLES = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic [31:0]      pc,
  input  logic             flush,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             fetch_err,
  output logic             busy,
  output logic [31:0]      mem_addr,
  input  logic [127:0]     mem_line,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int              FC_W      = $clog2(FILL_CYCLES + 1);
  localparam logic [FC_W-1:0] FILL_LAST = FC_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Word 0 sits in the most significant 32 bits of the line.
  function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] k);
    logic [31:0] w;
    case (k)
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      2'd3:    w = line[31:0];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  logic [1:0]      state_r;
  logic [127:0]    line_data_r;
  logic [27:0]     line_tag_r;
  logic            line_valid_r;
  logic [1:0]      word_sel_r;
  logic [FC_W-1:0] fill_cnt_r;

  logic aligned_s;
  logic hit_s;

  // Request decode against the buffered line.
  always_comb begin
    aligned_s = 1'b0;
    hit_s     = 1'b0;
    if (pc[1:0] == 2'b00) begin
      aligned_s = 1'b1;
    end else begin
      aligned_s = 1'b0;
    end
    if (line_valid_r && (line_tag_r == pc[31:4])) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Fetch state machine, line buffer, outputs and statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      line_data_r  <= 128'd0;
      line_tag_r   <= 28'd0;
      line_valid_r <= 1'b0;
      word_sel_r   <= 2'd0;
      fill_cnt_r   <= {FC_W{1'b0}};
      instr        <= 32'd0;
      instr_valid  <= 1'b0;
      fetch_err    <= 1'b0;
      busy         <= 1'b0;
      mem_addr     <= 32'd0;
      hit_count    <= {CNT_W{1'b0}};
      miss_count   <= {CNT_W{1'b0}};
    end else begin
      instr_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (flush) begin
            line_valid_r <= 1'b0;
          end else if (req) begin
            if (!aligned_s) begin
              instr       <= 32'd0;
              instr_valid <= 1'b1;
              fetch_err   <= 1'b1;
            end else if (hit_s) begin
              instr       <= line_word(line_data_r, pc[3:2]);
              instr_valid <= 1'b1;
              fetch_err   <= 1'b0;
              hit_count   <= sat_inc(hit_count);
            end else begin
              mem_addr     <= {pc[31:4], 4'b0000};
              word_sel_r   <= pc[3:2];
              fill_cnt_r   <= {FC_W{1'b0}};
              line_valid_r <= 1'b0;
              miss_count   <= sat_inc(miss_count);
              state_r      <= ST_FILL;
              busy         <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FILL: begin
          if (flush) begin
            line_valid_r <= 1'b0;
            state_r      <= ST_IDLE;
            busy         <= 1'b0;
          end else begin
            fill_cnt_r <= fill_cnt_r + FC_W'(1);
            if (fill_cnt_r == FILL_LAST) begin
              line_data_r  <= mem_line;
              line_tag_r   <= mem_addr[31:4];
              line_valid_r <= 1'b1;
              state_r      <= ST_RESP;
            end else begin
              state_r <= ST_FILL;
            end
          end
        end
        ST_RESP: begin
          if (flush) begin
            line_valid_r <= 1'b0;
          end else begin
            instr       <= line_word(line_data_r, word_sel_r);
            instr_valid <= 1'b1;
            fetch_err   <= 1'b0;
          end
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
